// File: rtl/count_checker.sv
// rtl/count_checker.sv - increment-by-one checker for a free-running COUNT bus
// Optional feature: define COUNT_CHECKER_STICKY_EN for an ERR flag that holds until reset.
module count_checker #(
  parameter int WIDTH         = 4,
  parameter int LOCK_THRESH   = 3,
  parameter int UNLOCK_THRESH = 2,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [WIDTH-1:0]     count_i,
  output logic                 locked_o,
  output logic                 mismatch_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_count_o,
  output logic [WIDTH-1:0]     expected_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SYNC   = 2'd1,
    S_LOCKED = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic [3:0]           run_q, run_d;
  logic [3:0]           miss_q, miss_d;
  logic                 locked_q, locked_d;
  logic                 mismatch_q, mismatch_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic [WIDTH-1:0]     expected;
  logic                 match;
  logic [3:0]           run_next;
  logic [3:0]           miss_next;

  assign expected = prev_q + {{(WIDTH-1){1'b0}}, 1'b1};
  assign match    = (count_i == expected);

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    run_d       = run_q;
    miss_d      = miss_q;
    mismatch_d  = 1'b0;
    err_count_d = err_count_q;
    run_next    = match ? (run_q + 4'd1) : 4'd0;
    miss_next   = miss_q + 4'd1;

    if (en_i) begin
      // Every enabled sample re-anchors PREV, so a glitch costs two mismatches.
      prev_d = count_i;
      unique case (state_q)
        S_IDLE: begin
          run_d   = 4'd0;
          state_d = S_SYNC;
        end
        S_SYNC: begin
          run_d = run_next;
          if (run_next == 4'(LOCK_THRESH)) begin
            state_d = S_LOCKED;
            miss_d  = 4'd0;
          end
        end
        S_LOCKED: begin
          if (match) begin
            miss_d = 4'd0;
          end else begin
            mismatch_d = 1'b1;
            miss_d     = miss_next;
            if (err_count_q != {ERR_CNT_W{1'b1}}) begin
              err_count_d = err_count_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end
            if (miss_next == 4'(UNLOCK_THRESH)) begin
              state_d = S_SYNC;
              run_d   = 4'd0;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    locked_d = (state_d == S_LOCKED);

`ifdef COUNT_CHECKER_STICKY_EN
    err_d = err_q | mismatch_d;
`else
    // Leaving LOCKED keeps MISS non-zero internally, so gate the flag on the state.
    err_d = (state_d == S_LOCKED) && (miss_d != 4'd0);
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      prev_q      <= '0;
      run_q       <= 4'd0;
      miss_q      <= 4'd0;
      locked_q    <= 1'b0;
      mismatch_q  <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      mismatch_q  <= mismatch_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked_o    = locked_q;
  assign mismatch_o  = mismatch_q;
  assign err_o       = err_q;
  assign err_count_o = err_count_q;
  assign expected_o  = expected;

endmodule

// File: tb/tb_count_checker.sv
// tb/tb_count_checker.sv - randomized self-checking bench for count_checker
// Honours COUNT_CHECKER_STICKY_EN for the ERR expectation.
module tb_count_checker;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       en_i = 1'b0;
  logic [3:0] count_i = 4'd0;

  logic       locked_o, mismatch_o, err_o;
  logic [7:0] err_count_o;
  logic [3:0] expected_o;

  logic       s_locked, s_mismatch, s_err;
  logic [1:0] s_err_count;
  logic [3:0] s_expected;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain integers following the specification's rules.
  int m_phase;   // 0 = unanchored, 1 = hunting, 2 = locked
  int m_prev, m_run, m_miss, m_errs;
  bit m_mm, m_err;

  always #5 clk_i = ~clk_i;

  count_checker #(.WIDTH(4), .LOCK_THRESH(3), .UNLOCK_THRESH(2), .ERR_CNT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .count_i(count_i),
    .locked_o(locked_o), .mismatch_o(mismatch_o), .err_o(err_o),
    .err_count_o(err_count_o), .expected_o(expected_o)
  );

  count_checker #(.WIDTH(4), .LOCK_THRESH(3), .UNLOCK_THRESH(2), .ERR_CNT_W(2)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .count_i(count_i),
    .locked_o(s_locked), .mismatch_o(s_mismatch), .err_o(s_err),
    .err_count_o(s_err_count), .expected_o(s_expected)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_prev = 0; m_run = 0; m_miss = 0; m_errs = 0;
    m_mm = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_sample(input bit en, input int cnt);
    bit ok;
    m_mm = 1'b0;
    if (!en) return;
    ok = (cnt == ((m_prev + 1) % 16));
    if (m_phase == 0) begin
      m_run = 0;
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_run = ok ? m_run + 1 : 0;
      if (m_run == 3) begin
        m_phase = 2;
        m_miss = 0;
      end
    end else begin
      if (ok) m_miss = 0;
      else begin
        m_mm = 1'b1;
        m_errs++;
        m_miss++;
        if (m_miss == 2) begin
          m_phase = 1;
          m_run = 0;
        end
      end
    end
    m_prev = cnt;
`ifdef COUNT_CHECKER_STICKY_EN
    m_err = m_err | m_mm;
`else
    m_err = (m_phase == 2) && (m_miss != 0);
`endif
  endtask

  task automatic check_all();
    check_eq("locked", 32'(locked_o), 32'(m_phase == 2));
    check_eq("mismatch", 32'(mismatch_o), 32'(m_mm));
    check_eq("err", 32'(err_o), 32'(m_err));
    check_eq("err_count", 32'(err_count_o), 32'((m_errs > 255) ? 255 : m_errs));
    check_eq("expected", 32'(expected_o), 32'((m_prev + 1) % 16));
    check_eq("sat_err_count", 32'(s_err_count), 32'((m_errs > 3) ? 3 : m_errs));
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_locked"}, 32'(locked_o), 32'd0);
    check_eq({tag, "_mismatch"}, 32'(mismatch_o), 32'd0);
    check_eq({tag, "_err"}, 32'(err_o), 32'd0);
    check_eq({tag, "_err_count"}, 32'(err_count_o), 32'd0);
    check_eq({tag, "_expected"}, 32'(expected_o), 32'd1);
    check_eq({tag, "_sat_err_count"}, 32'(s_err_count), 32'd0);
  endtask

  task automatic step(input bit en, input int cnt);
    @(negedge clk_i);
    en_i = en;
    count_i = 4'(cnt);
    @(posedge clk_i);
    #1;
    model_sample(en, cnt);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    en_i = 1'b0;
    #1;
    model_reset();
    check_reset_values("reset");
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Lock from wherever the model is, then inject the 6,9,8-style glitch.
  task automatic lock_and_glitch();
    int p;
    for (int i = 0; i < 4; i++) step(1'b1, (m_prev + 1) % 16);
    p = m_prev;
    step(1'b1, (p + 1) % 16);
    step(1'b1, (p + 4) % 16);
    step(1'b1, (p + 3) % 16);
  endtask

  initial begin
    model_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_values("por");
    @(negedge clk_i);
    rst_i = 1'b0;

    // Lock on 0..3, then one more sample
    for (int v = 0; v <= 4; v++) begin
      step(1'b1, v);
      if (v == 3) check_eq("lock_after_3", 32'(locked_o), 32'd1);
    end
    check_eq("lock_expected", 32'(expected_o), 32'd5);
    check_eq("lock_err_count", 32'(err_count_o), 32'd0);

    // Run up through the wrap
    for (int v = 5; v <= 17; v++) begin
      step(1'b1, v % 16);
      check_eq("wrap_no_mismatch", 32'(mismatch_o), 32'd0);
      check_eq("wrap_locked", 32'(locked_o), 32'd1);
    end

    // Reach 5 and glitch
    for (int v = 2; v <= 5; v++) step(1'b1, v);
    step(1'b1, 6);
    step(1'b1, 9);
    check_eq("glitch_mm1", 32'(mismatch_o), 32'd1);
    check_eq("glitch_locked_mid", 32'(locked_o), 32'd1);
    check_eq("glitch_err_mid", 32'(err_o), 32'd1);
    step(1'b1, 8);
    check_eq("glitch_mm2", 32'(mismatch_o), 32'd1);
    check_eq("glitch_err_count", 32'(err_count_o), 32'd2);
    check_eq("glitch_unlocked", 32'(locked_o), 32'd0);

    // Relock and walk to 7
    for (int v = 9; v <= 23; v++) step(1'b1, v % 16);
    check_eq("freeze_pre_locked", 32'(locked_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 3);
      check_eq("freeze_expected", 32'(expected_o), 32'd8);
      check_eq("freeze_no_mismatch", 32'(mismatch_o), 32'd0);
    end
    step(1'b1, 8);
    check_eq("freeze_resume_mm", 32'(mismatch_o), 32'd0);
    check_eq("freeze_resume_locked", 32'(locked_o), 32'd1);

    // Asynchronous reset in mid-cycle while locked with two errors
    check_eq("areset_pre_count", 32'(err_count_o), 32'd2);
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    model_reset();
    check_reset_values("areset");
    @(negedge clk_i);
    en_i = 1'b1;
    count_i = 4'd7;
    @(posedge clk_i);
    #1;
    check_reset_values("areset_hold");
    @(negedge clk_i);
    rst_i = 1'b0;
    en_i = 1'b0;

    // Saturation of the narrow counter
    for (int k = 0; k < 3; k++) lock_and_glitch();
    check_eq("sat_wide_count", 32'(err_count_o), 32'd6);
    check_eq("sat_narrow_count", 32'(s_err_count), 32'd3);
    lock_and_glitch();
    check_eq("sat_narrow_hold", 32'(s_err_count), 32'd3);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 900; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 1) begin
        do_reset();
      end else begin
        bit en;
        int cnt;
        en = ($urandom_range(0, 9) < 8);
        if ($urandom_range(0, 99) < 88) cnt = (m_prev + 1) % 16;
        else cnt = int'($urandom_range(0, 15));
        step(en, cnt);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/count_checker.md
# count_checker

Monitors the COUNT bus of a free-running counter and verifies, cycle by cycle, that it increments by one modulo 2^WIDTH. It locks onto the observed sequence, flags and counts deviations, and drops lock after repeated misses. It sits on the consuming end of the counter's COUNT interface in the same clock domain, as an in-design health monitor and a bench-side scoreboard.

## Interface
- WIDTH, 4: width of the monitored count.
- LOCK_THRESH, 3: consecutive correct increments required to enter LOCKED (1..15).
- UNLOCK_THRESH, 2: consecutive mismatches in LOCKED that force return to SYNC (1..15).
- ERR_CNT_W, 8: width of the saturating mismatch counter.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- EN  input  1  sample enable; high = COUNT_IN valid this cycle.
- COUNT_IN  input  WIDTH  counter value under check.
- LOCKED  output  1  checker is locked to the sequence.
- MISMATCH  output  1  one-cycle pulse: the last sample was wrong while LOCKED.
- ERR  output  1  error flag (see Configuration).
- ERR_COUNT  output  ERR_CNT_W  total mismatches, saturating.
- EXPECTED  output  WIDTH  value required at the next enabled sample (PREV+1).

## Operation
- Internal registers:
  - PREV (WIDTH): last enabled sample.
  - RUN (4 bits): consecutive correct increments.
  - MISS (4 bits): consecutive mismatches.
  - State: IDLE, SYNC, LOCKED.
- Match means COUNT_IN == PREV+1 mod 2^WIDTH. This includes the wrap from 2^WIDTH-1 to 0.
- EN=0: the checker freezes. State, PREV, RUN, MISS and ERR_COUNT hold. MISMATCH=0.
- With EN=1, the states behave as follows:
  - IDLE: PREV<=COUNT_IN, RUN<=0, then go to SYNC.
  - SYNC: on a match, RUN<=RUN+1; otherwise RUN<=0. PREV<=COUNT_IN. When the updated RUN equals LOCK_THRESH, go to LOCKED with MISS<=0.
  - LOCKED, on a match: MISS<=0.
  - LOCKED, on a mismatch: MISMATCH pulses, ERR_COUNT increments (saturating at all-ones), and MISS<=MISS+1. When the updated MISS equals UNLOCK_THRESH, go to SYNC with RUN<=0.
  - LOCKED: PREV<=COUNT_IN always. The checker re-anchors to the observed value, so a single glitched sample produces two mismatches (the glitch and the recovery).
- Mismatches are not counted in IDLE or SYNC.
- EXPECTED = PREV+1 mod 2^WIDTH, combinational from PREV.

## Timing
- Reset values:
  - State=IDLE, PREV=0, RUN=0, MISS=0.
  - LOCKED=0, MISMATCH=0, ERR=0, ERR_COUNT=0.
  - EXPECTED=1.
- RESET asserted mid-operation clears everything asynchronously and has priority over EN. After release, the first enabled edge is handled as IDLE.
- All outputs except EXPECTED are registered. They update on the edge that samples COUNT_IN, so they are visible one cycle after the sampled value was presented.
- LOCKED rises on the edge that samples the LOCK_THRESH-th consecutive match. With LOCK_THRESH=3 this takes 4 enabled samples from IDLE.
- LOCKED falls on the edge that samples the UNLOCK_THRESH-th consecutive mismatch. That edge also pulses MISMATCH and increments ERR_COUNT.
- MISMATCH is high for exactly one cycle per mismatching enabled sample. Back-to-back mismatches hold it high across consecutive cycles.
- ERR_COUNT at all-ones stays there; MISMATCH still pulses.

## Configuration
- COUNT_CHECKER_STICKY_EN defined: ERR sets on the first mismatch in LOCKED. It stays high until RESET, regardless of later matches or loss of lock.
- Not defined: ERR is high exactly while MISS != 0. It clears on the edge sampling the next match or on exit from LOCKED.

## Test plan
- Lock: reset, EN=1, COUNT_IN 0,1,2,3,4 on successive edges. Required: LOCKED=1 after the edge sampling 3; EXPECTED=5 after sampling 4; ERR_COUNT=0.
- Wrap: once locked, drive 14,15,0,1. Required: no MISMATCH, LOCKED stays 1.
- Single glitch: locked at 5, drive 6,9,8. Required:
  - MISMATCH pulses after sampling 9 and after sampling 8; ERR_COUNT=2.
  - LOCKED falls after sampling 8 (UNLOCK_THRESH=2).
  - ERR: sticky build stays 1; non-sticky build is 1 until the state change.
- Freeze: locked at 7, EN=0 for 5 cycles with COUNT_IN=3, then EN=1 with 8. Required: no MISMATCH, LOCKED=1, EXPECTED=8 throughout the freeze.
- Saturation: ERR_CNT_W=2, six mismatches while locked (re-lock as needed). Required: ERR_COUNT=3 and stays 3.
- Async reset: assert RESET mid-cycle while LOCKED with ERR_COUNT=2. Required: all outputs reach reset values before the next CLK edge; EXPECTED=1.
